// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: active-high patterns in {g,f,e,d,c,b,a}
// order and the digit count.
package display_pkg;

  localparam int unsigned N_DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // True when any nibble of the packed BCD word is not a decimal digit.
  function automatic logic bcd_has_err(logic [15:0] v);
    logic err;
    err = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD nibble to active-high seven-segment pattern; non-decimal nibbles show "E".
module bcd7seg_dec
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed seven-segment driver with frame-boundary double buffering,
// leading-zero blanking and non-decimal nibble flagging.
module bcd_scan_display
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned GUARD      = 2,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_sync,
  output logic        bcd_err
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic [1:0]      dig_q;
  logic [15:0]     pend_q;
  logic            pend_v_q;
  logic [15:0]     disp_q;
  logic [6:0]      seg_q;
  logic [3:0]      an_q;
  logic            frame_sync_q;
  logic            bcd_err_q;

  logic            slot_end;
  logic            frame_end;
  logic [3:0]      blank;
  logic [3:0]      nib;
  logic [6:0]      pat;
  logic [3:0]      an_next;

  assign slot_end  = (cnt_q == CntW'(CLK_DIV - 1));
  assign frame_end = slot_end && (dig_q == 2'd3);

  // Digit k is blank when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    blank = 4'b0000;
    if (BLANK_LZ) begin
      blank[3] = (disp_q[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
      blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    end
  end

  assign nib = disp_q[{dig_q, 2'b00} +: 4];

  bcd7seg_dec u_dec (
    .nibble (nib),
    .blank  (blank[dig_q]),
    .seg    (pat)
  );

  assign an_next = (cnt_q < CntW'(GUARD)) ? 4'b0000 : (4'b0001 << dig_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      pend_q       <= 16'h0000;
      pend_v_q     <= 1'b0;
      disp_q       <= 16'h0000;
      seg_q        <= ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
      an_q         <= ACTIVE_LOW ? 4'b1111 : 4'b0000;
      frame_sync_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) dig_q <= dig_q + 2'd1;

      frame_sync_q <= frame_end && pend_v_q;
      if (frame_end && pend_v_q) begin
        disp_q    <= pend_q;
        pend_v_q  <= 1'b0;
        bcd_err_q <= bcd_has_err(pend_q);
      end
      // A load on the boundary edge lands after the commit, so it waits one more frame.
      if (load) begin
        pend_q   <= bcd_in;
        pend_v_q <= 1'b1;
      end

      seg_q <= ACTIVE_LOW ? ~pat : pat;
      an_q  <= ACTIVE_LOW ? ~an_next : an_next;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_sync = frame_sync_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench: stimulus queues per-frame and per-digit-slot expectations; a negedge
// monitor pops and compares them as the DUT lights each slot and starts each frame.
module tb_bcd_scan_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_sync;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;

  typedef struct packed {
    logic fs;
    logic err;
  } frame_t;

  slot_t  slot_q[$];
  frame_t frame_q[$];

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P4 = 7'b1100110;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] P7 = 7'b0000111;
  localparam logic [6:0] PE = 7'b1111001;
  localparam logic [6:0] PB = 7'b0000000;

  bcd_scan_display #(
    .CLK_DIV    (8),
    .GUARD      (2),
    .ACTIVE_LOW (1'b0),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_sync (frame_sync),
    .bcd_err    (bcd_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1);
  end

  // Monitor: k counts cycles since reset release; outputs lag the scan state by one cycle.
  initial begin : monitor
    int k;
    slot_t  cur_slot;
    frame_t cur_frame;
    bit lit_exp;
    k = 0;
    cur_slot = '0;
    cur_frame = '0;
    forever begin
      @(negedge clock);
      if (!run) begin
        k = 0;
      end else begin
        lit_exp = (k != 0) && (((k % 8) >= 3) || ((k % 8) == 0));
        checks++;
        if ((an != 4'b0000) != lit_exp) begin
          errors++;
          $display("FAIL an_activity k=%0d: an=%b, lit required=%0d", k, an, lit_exp);
        end
        if ((k % 8) == 0 && k != 0) begin
          checks++;
          if (an != cur_slot.an || seg != cur_slot.seg) begin
            errors++;
            $display("FAIL slot_end k=%0d: an=%b seg=%b, required an=%b seg=%b",
                     k, an, seg, cur_slot.an, cur_slot.seg);
          end
        end
        if ((k % 8) == 3) begin
          checks++;
          if (slot_q.size() == 0) begin
            errors++;
            $display("FAIL slot_underflow k=%0d: no expectation queued", k);
          end else begin
            cur_slot = slot_q.pop_front();
            if (an != cur_slot.an || seg != cur_slot.seg) begin
              errors++;
              $display("FAIL slot k=%0d: an=%b seg=%b, required an=%b seg=%b",
                       k, an, seg, cur_slot.an, cur_slot.seg);
            end
          end
        end
        if ((k % 32) == 0) begin
          checks++;
          if (frame_q.size() == 0) begin
            errors++;
            $display("FAIL frame_underflow k=%0d: no expectation queued", k);
          end else begin
            cur_frame = frame_q.pop_front();
            if (frame_sync != cur_frame.fs) begin
              errors++;
              $display("FAIL frame_sync k=%0d: got %b, required %b", k, frame_sync, cur_frame.fs);
            end
          end
        end else begin
          checks++;
          if (frame_sync != 1'b0) begin
            errors++;
            $display("FAIL frame_sync_extra k=%0d: got %b, required 0", k, frame_sync);
          end
        end
        checks++;
        if (bcd_err != cur_frame.err) begin
          errors++;
          $display("FAIL bcd_err k=%0d: got %b, required %b", k, bcd_err, cur_frame.err);
        end
        k++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input logic fs, input logic err, input logic [6:0] s0,
                            input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    frame_q.push_back('{fs: fs, err: err});
    slot_q.push_back('{an: 4'b0001, seg: s0});
    slot_q.push_back('{an: 4'b0010, seg: s1});
    slot_q.push_back('{an: 4'b0100, seg: s2});
    slot_q.push_back('{an: 4'b1000, seg: s3});
  endtask

  // One 32-cycle frame with up to two loads at the given offsets (-1 = none).
  task automatic run_frame(input logic fs, input logic err, input logic [6:0] s0,
                           input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                           input logic [15:0] v1, input int o1,
                           input logic [15:0] v2, input int o2);
    push_frame(fs, err, s0, s1, s2, s3);
    for (int i = 0; i < 32; i++) begin
      load = 1'b0;
      if (i == o1) begin load = 1'b1; bcd_in = v1; end
      if (i == o2) begin load = 1'b1; bcd_in = v2; end
      next_cycle();
    end
    load = 1'b0;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    run = 1'b1;
  endtask

  initial begin : stimulus
    release_reset();
    // Reset value: units "0", upper digits blanked; load 0x1234 mid-frame.
    run_frame(1'b0, 1'b0, P0, PB, PB, PB, 16'h1234, 12, 16'h0, -1);
    run_frame(1'b1, 1'b0, P4, P3, P2, P1, 16'h0050, 5, 16'h0, -1);
    run_frame(1'b1, 1'b0, P0, P5, PB, PB, 16'h0A07, 7, 16'h0, -1);
    run_frame(1'b1, 1'b1, P7, P0, PE, PB, 16'h0007, 20, 16'h0, -1);
    run_frame(1'b1, 1'b0, P7, PB, PB, PB, 16'h0, -1, 16'h0, -1);
    // No pending value: no frame_sync. Then last write wins within a frame.
    run_frame(1'b0, 1'b0, P7, PB, PB, PB, 16'h1111, 3, 16'h2222, 20);
    // 0x4444 pending, 0x3333 loaded on the boundary cycle.
    run_frame(1'b1, 1'b0, P2, P2, P2, P2, 16'h4444, 10, 16'h3333, 31);
    run_frame(1'b1, 1'b0, P4, P4, P4, P4, 16'h0, -1, 16'h0, -1);

    // Partial frame: load 0x9999, then reset before the boundary.
    frame_q.push_back('{fs: 1'b1, err: 1'b0});
    slot_q.push_back('{an: 4'b0001, seg: P3});
    for (int i = 0; i < 10; i++) begin
      load = (i == 2);
      if (i == 2) bcd_in = 16'h9999;
      next_cycle();
    end
    load = 1'b0;
    reset = 1'b1;
    run = 1'b0;
    release_reset();
    run_frame(1'b0, 1'b0, P0, PB, PB, PB, 16'h0, -1, 16'h0, -1);
    run_frame(1'b0, 1'b0, P0, PB, PB, PB, 16'h0, -1, 16'h0, -1);
    run = 1'b0;
    @(negedge clock);

    checks++;
    if (slot_q.size() != 0 || frame_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d slots and %0d frames left, required 0",
               slot_q.size(), frame_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed four-digit seven-segment driver that consumes the 16-bit packed BCD word produced by the binary-to-BCD converter and scans it onto a common-anode/common-cathode display. It double-buffers the BCD value so that updates only take effect at frame boundaries, which prevents torn frames. It also blanks leading zeros and flags non-decimal nibbles. It sits between the processor's output path (after BCD conversion) and the board display pins.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot; legal values are ≥ `GUARD`+2.
- `GUARD`, 2: cycles at the start of each slot during which all anodes are off (anti-ghosting).
- `ACTIVE_LOW`, 1: polarity of `seg` and `an`. 1 = driven low means on.
- `BLANK_LZ`, 1: enable leading-zero blanking.
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: **synchronous, active-high**.
- `bcd_in` in 16: packed BCD, with the thousands digit in [15:12] and the units digit in [3:0].
- `load` in 1: capture `bcd_in` into the pending register this cycle.
- `seg` out 7: {g,f,e,d,c,b,a}, registered.
- `an` out 4: digit enables, one-hot when active, with an[0] = units; registered.
- `frame_sync` out 1: one-cycle pulse on each commit of pending to display.
- `bcd_err` out 1: set if the committed display value contains a nibble > 9; held until the next commit.

## Operation
- Registers:
  - `pend[15:0]` and a `pend_v` flag.
  - `disp[15:0]`.
  - slot counter `cnt` (0..CLK_DIV-1).
  - digit index `dig` (0..3).
- Load: when `load`=1, `pend`←`bcd_in` and `pend_v`←1. A later load before the commit overwrites the earlier one (last write wins).
- Scan: `cnt` increments every cycle. When `cnt`=CLK_DIV-1, `cnt`←0 and `dig`←`dig`+1 mod 4.
- Frame boundary is the cycle where `cnt`=CLK_DIV-1 and `dig`=3. At that edge, if `pend_v`=1:
  - `disp`←`pend` and `pend_v`←0.
  - `frame_sync` pulses the next cycle.
  - `bcd_err` is recomputed from the new `disp`.
- Load coinciding with the boundary edge: the commit uses the old `pend`. The new value goes to `pend` with `pend_v`=1 and is committed at the following boundary.
- Digit decode:
  - 0–9 use standard patterns.
  - A nibble > 9 shows "E" (segments a,d,e,f,g).
  - Blanked shows all segments off.
- Leading-zero blanking (`BLANK_LZ`=1): digit k (k=1..3) is blanked when `disp` nibbles k..3 are all zero. Digit 0 is never blanked. A nibble > 9 is never treated as zero.
- `an`:
  - Inactive on all digits when `cnt` < `GUARD`.
  - Otherwise only `an[dig]` is active.
  - A blanked digit still asserts its anode, with `seg` all off.
- Polarity: when `ACTIVE_LOW`=1, `seg` and `an` are inverted at the output register only; all internal logic is active-high.

## Timing
- Reset (while `reset`=1 and on the first cycle after release):
  - `cnt`=0, `dig`=0, `pend`=0, `pend_v`=0, `disp`=0.
  - `an` all inactive, `seg` all off, `frame_sync`=0, `bcd_err`=0.
- Reset asserted mid-frame or with a pending load discards the pending value and restarts at digit 0. There is no partial commit.
- Output latency: `seg`/`an` reflect the (`cnt`,`dig`,`disp`) state of the previous cycle (one register stage).
- Load-to-display latency:
  - Minimum 1 cycle (load on the cycle before the boundary edge).
  - Maximum 4·CLK_DIV cycles to commit, plus 1 cycle to output.
- `frame_sync` is high for exactly 1 cycle, the cycle after the commit edge. It never fires without `pend_v`.
- Full frame period is 4·CLK_DIV cycles. Each digit is lit for CLK_DIV−GUARD cycles per frame.

## Structure
- Shared package `display_pkg`:
  - Segment pattern constants (`SEG_0`..`SEG_9`, `SEG_E`, `SEG_OFF`), in {g..a} order, active-high.
  - Digit-count constant `N_DIGITS`=4.
- Sub-module `bcd7seg_dec`: a combinational 4-bit nibble plus blank input, producing a 7-bit active-high pattern. It is instantiated once, fed by a mux on `dig`.
- The top level holds the counters, the pend/disp buffering, the blanking logic and the output registers.

## Test plan
Bench parameters: `CLK_DIV`=8, `GUARD`=2, `ACTIVE_LOW`=0, `BLANK_LZ`=1.

- **Reset:** hold reset 3 cycles, release. Required: `an`=0000 for cycles 0–2 after release; then `an`=0001 with `seg`=0111111 ("0"), and digits 1–3 blanked (`seg`=0 when lit).
- **Commit:** load `bcd_in`=0x1234 mid-frame. Required:
  - `disp` unchanged until the dig=3/cnt=7 edge.
  - `frame_sync` pulses once.
  - The next frame shows 4,3,2,1 on an[0..3] as 1100110, 1001111, 1011011, 0000110.
- **Leading-zero blanking:** load 0x0050. Required: digits 3 and 2 blanked, digit 1 shows "5" (1101101), digit 0 shows "0".
- **Error nibble:** load 0x0A07. Required:
  - `bcd_err`=1 after the commit.
  - Digit 2 shows "E" (1111001), and digit 3 is blanked.
  - A later load of 0x0007 clears `bcd_err` at the next commit.
- **Load collisions:**
  - Load 0x1111 then 0x2222 within the same frame: only 0x2222 is displayed.
  - Load 0x3333 on the boundary cycle: the old pending value commits, and 0x3333 appears one frame later with a second `frame_sync`.
- **Reset mid-operation:** load 0x9999, then assert reset before the boundary. Required: after release `frame_sync` never fires and the display shows "0".
